// File: rtl/key_filter.sv
// Pushbutton debouncer: 2-flop synchronizer, edge detect, 4-state filter FSM.
// Define LONG_PRESS_EN to add the long-press counter driving Long_flag.
module key_filter #(
  parameter int CNT_MAX  = 999999,
  parameter int LONG_MAX = 49999999
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Key_in,
  output logic       Key_flag,
  output logic       Rel_flag,
  output logic       Key_state,
  output logic       Long_flag,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);

  typedef enum logic [1:0] {IDLE, FILTER0, DOWN, FILTER1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          key_flag_nxt, rel_flag_nxt, key_state_nxt;
  logic          s1, s2, s3;
  logic          fall, rise;

  assign fall      = ~s2 & s3;
  assign rise      = s2 & ~s3;
  assign dbg_state = state;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= Key_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      Key_flag  <= 1'b0;
      Rel_flag  <= 1'b0;
      Key_state <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      Key_flag  <= key_flag_nxt;
      Rel_flag  <= rel_flag_nxt;
      Key_state <= key_state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    key_flag_nxt  = 1'b0;
    rel_flag_nxt  = 1'b0;
    key_state_nxt = Key_state;
    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = FILTER0;
          cnt_nxt   = '0;
        end
      end
      FILTER0: begin
        if (rise) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_TOP) begin
          cnt_nxt = '0;
          // A level that is no longer low at the terminal count is treated as a bounce.
          if (!s2) begin
            state_nxt     = DOWN;
            key_flag_nxt  = 1'b1;
            key_state_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DOWN: begin
        if (rise) begin
          state_nxt = FILTER1;
          cnt_nxt   = '0;
        end
      end
      FILTER1: begin
        if (fall) begin
          state_nxt = DOWN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_TOP) begin
          cnt_nxt = '0;
          if (s2) begin
            state_nxt     = IDLE;
            rel_flag_nxt  = 1'b1;
            key_state_nxt = 1'b1;
          end else begin
            state_nxt = DOWN;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef LONG_PRESS_EN
  localparam int LW = $clog2(LONG_MAX + 1);
  localparam logic [LW-1:0] LONG_TOP = LW'(LONG_MAX);

  logic [LW-1:0] long_cnt;
  logic          long_done;

  // long_done survives a release bounce so one press yields at most one Long_flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      long_cnt  <= '0;
      long_done <= 1'b0;
      Long_flag <= 1'b0;
    end else begin
      Long_flag <= 1'b0;
      if (state_nxt == DOWN && state != DOWN) begin
        long_cnt <= '0;
        if (state == FILTER0) long_done <= 1'b0;
      end else if (state_nxt == IDLE) begin
        long_cnt  <= '0;
        long_done <= 1'b0;
      end else if (state == DOWN || state == FILTER1) begin
        if (long_cnt == LONG_TOP) begin
          if (!long_done) begin
            Long_flag <= 1'b1;
            long_done <= 1'b1;
          end
        end else begin
          long_cnt <= long_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign Long_flag = 1'b0;
`endif

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with CNT_MAX=99, LONG_MAX=499.
// Latencies are counted in rising edges from the edge that first samples a new Key_in level.
module tb_key_filter;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Key_in;
  logic       Key_flag, Rel_flag, Key_state, Long_flag;
  logic [1:0] dbg_state;

  key_filter #(.CNT_MAX(99), .LONG_MAX(499)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Key_in    (Key_in),
    .Key_flag  (Key_flag),
    .Rel_flag  (Rel_flag),
    .Key_state (Key_state),
    .Long_flag (Long_flag),
    .dbg_state (dbg_state)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_no  = 0;
  int e0;
  int kf_n, rf_n, lf_n, kf_first, rf_first, lf_first, ks_at_kf, ks_low_n;
  int lf_total = 0;
  int overlap  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_obs();
    kf_n = 0; rf_n = 0; lf_n = 0;
    kf_first = -1; rf_first = -1; lf_first = -1;
    ks_at_kf = -1; ks_low_n = 0;
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge Clk);
    #1;
    edge_no++;
    if (Key_flag) begin
      kf_n++;
      if (kf_first < 0) begin
        kf_first = edge_no;
        ks_at_kf = int'(Key_state);
      end
    end
    if (Rel_flag) begin
      rf_n++;
      if (rf_first < 0) rf_first = edge_no;
    end
    if (Long_flag) begin
      lf_n++;
      lf_total++;
      if (lf_first < 0) lf_first = edge_no;
    end
    if (int'(Key_flag) + int'(Rel_flag) + int'(Long_flag) > 1) overlap++;
    if (!Key_state) ks_low_n++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int lat(input int first);
    return (first < 0) ? -1 : first - e0;
  endfunction

  initial begin
    Reset_n = 1'b0;
    Key_in  = 1'b1;
    clr_obs();
    run(3);
    check("reset_key_flag", int'(Key_flag), 0);
    check("reset_rel_flag", int'(Rel_flag), 0);
    check("reset_long_flag", int'(Long_flag), 0);
    check("reset_key_state", int'(Key_state), 1);
    check("reset_state", int'(dbg_state), 0);
    Reset_n = 1'b1;
    run(5);

    // Clean press
    clr_obs();
    Key_in = 1'b0;
    e0 = edge_no + 1;
    run(150);
    check("press_pulses", kf_n, 1);
    check("press_latency", lat(kf_first), 102);
    check("press_state_at_flag", ks_at_kf, 0);
    check("press_no_rel", rf_n, 0);
    check("press_key_state", int'(Key_state), 0);
    check("press_fsm_down", int'(dbg_state), 2);

    // Short release bounce while held
    clr_obs();
    Key_in = 1'b1;
    run(30);
    Key_in = 1'b0;
    run(150);
    check("relglitch_no_rel", rf_n, 0);
    check("relglitch_key_state", int'(Key_state), 0);

    // Clean release
    clr_obs();
    Key_in = 1'b1;
    e0 = edge_no + 1;
    run(150);
    check("release_pulses", rf_n, 1);
    check("release_latency", lat(rf_first), 102);
    check("release_no_key", kf_n, 0);
    check("release_key_state", int'(Key_state), 1);

    // 50-cycle glitch
    clr_obs();
    Key_in = 1'b0;
    run(50);
    Key_in = 1'b1;
    run(200);
    check("glitch50_no_key", kf_n, 0);
    check("glitch50_no_rel", rf_n, 0);
    check("glitch50_state_held", ks_low_n, 0);

    // 99-cycle glitch, just under the window
    clr_obs();
    Key_in = 1'b0;
    run(99);
    Key_in = 1'b1;
    run(200);
    check("glitch99_no_key", kf_n, 0);
    check("glitch99_state_held", ks_low_n, 0);

    // Bounce: five toggles at 10-cycle intervals, then hold low
    clr_obs();
    Key_in = 1'b0; run(10);
    Key_in = 1'b1; run(10);
    Key_in = 1'b0; run(10);
    Key_in = 1'b1; run(10);
    check("bounce_no_flag", kf_n + rf_n, 0);
    Key_in = 1'b0;
    e0 = edge_no + 1;
    run(150);
    check("bounce_pulses", kf_n, 1);
    check("bounce_latency", lat(kf_first), 102);
    clr_obs();
    Key_in = 1'b1;
    run(150);
    check("bounce_release", rf_n, 1);

    // Reset in FILTER0 at cnt = 60
    clr_obs();
    Key_in = 1'b0;
    run(63);
    check("midfilter_in_filter0", int'(dbg_state), 1);
    Reset_n = 1'b0;
    #2;
    check("midfilter_rst_state", int'(dbg_state), 0);
    check("midfilter_rst_key_state", int'(Key_state), 1);
    check("midfilter_rst_key_flag", int'(Key_flag), 0);
    run(3);
    Reset_n = 1'b1;
    clr_obs();
    e0 = edge_no + 1;
    run(150);
    check("after_rst_pulses", kf_n, 1);
    check("after_rst_latency", lat(kf_first), 102);

    // Reset while pressed
    Reset_n = 1'b0;
    #2;
    check("down_rst_key_state", int'(Key_state), 1);
    check("down_rst_state", int'(dbg_state), 0);
    Key_in = 1'b1;
    run(3);
    Reset_n = 1'b1;
    clr_obs();
    run(150);
    check("down_rst_quiet", kf_n + rf_n, 0);
    check("down_rst_key_state_hold", int'(Key_state), 1);

    // Long hold
    clr_obs();
    Key_in = 1'b0;
    e0 = edge_no + 1;
    run(1100);
    check("long_key_pulses", kf_n, 1);
`ifdef LONG_PRESS_EN
    check("long_pulses", lf_n, 1);
    check("long_after_key", (lf_first < 0 || kf_first < 0) ? -1 : lf_first - kf_first, 500);
`else
    check("long_absent", lf_n, 0);
`endif
    clr_obs();
    Key_in = 1'b1;
    run(150);
    check("long_release", rf_n, 1);

    check("flags_exclusive", overlap, 0);
`ifdef LONG_PRESS_EN
    check("long_total", lf_total, 1);
`else
    check("long_total", lf_total, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
